// File: rtl/fetch_hazard_controller.sv
// Fetch-stage pipeline control: drives PC / IF/ID / ID/EX enables for branch redirects,
// load-use stalls and instruction-memory wait states, with a fetch-timeout watchdog.
//
// state | meaning
// BOOT  | first cycle after reset; pipe is flushed, PC held
// RUN   | normal fetch, no outstanding memory wait
// WAIT  | instruction memory not ready on the previous cycle(s)
// HALT  | fetch timed out; NOPs drain the pipe until reset
module fetch_hazard_controller #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PCSrc,
    input  logic        IMemReady,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UsesRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        Fault,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          fault_q, fault_d;
    logic [15:0]   stall_cnt_q, stall_cnt_d;
    logic [15:0]   flush_cnt_q, flush_cnt_d;
    logic [3:0]    en_vec;
    logic          hz;

    assign hz = EX_MemRead && (EX_Rt != 5'd0) &&
                ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        fault_d     = fault_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        en_vec      = 4'b0000;

        case (state_q)
            BOOT: begin
                en_vec  = 4'b0011;
                state_d = RUN;
            end
            HALT: begin
                en_vec = 4'b0110;
            end
            RUN, WAIT: begin
                if (PCSrc) begin
                    // redirect overrides stall and wait; the wrong-path fetch is flushed
                    en_vec     = 4'b1111;
                    wait_cnt_d = '0;
                    state_d    = RUN;
                    if (flush_cnt_q != CNT_MAX)
                        flush_cnt_d = flush_cnt_q + 16'd1;
                end else begin
                    if (hz) begin
                        en_vec = 4'b0001;
                        if (stall_cnt_q != CNT_MAX)
                            stall_cnt_d = stall_cnt_q + 16'd1;
                    end else if (!IMemReady) begin
                        en_vec = 4'b0110;
                    end else begin
                        en_vec = 4'b1100;
                    end

                    // not-ready cycles count toward the timeout even under a stall
                    if (!IMemReady) begin
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d = HALT;
                            fault_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CW'(1);
                            state_d    = WAIT;
                        end
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = RUN;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= BOOT;
            wait_cnt_q  <= '0;
            fault_q     <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            fault_q     <= fault_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble} = en_vec;
    assign Fault      = fault_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// Bench for fetch_hazard_controller: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the fetch control rules.
module tb_fetch_hazard_controller;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        PCSrc = 1'b0;
    logic        IMemReady = 1'b1;
    logic [4:0]  ID_Rs = 5'd0;
    logic [4:0]  ID_Rt = 5'd0;
    logic        ID_UsesRt = 1'b0;
    logic        EX_MemRead = 1'b0;
    logic [4:0]  EX_Rt = 5'd0;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, Fault;
    logic [15:0] StallCount, FlushCount;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    bit m_boot;
    bit m_halt;
    bit m_fault;
    int m_waits;
    int m_stalls;
    int m_flushes;

    fetch_hazard_controller #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .PCSrc(PCSrc), .IMemReady(IMemReady),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXBubble(IDEXBubble), .Fault(Fault),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 Clk = ~Clk;

    function automatic bit model_hazard();
        int rs, rt, ex;
        rs = ID_Rs; rt = ID_Rt; ex = EX_Rt;
        return EX_MemRead && ex != 0 && (ex == rs || (ID_UsesRt && ex == rt));
    endfunction

    function automatic logic [3:0] exp_out();
        if (m_boot)       return 4'b0011;
        if (m_halt)       return 4'b0110;
        if (PCSrc)        return 4'b1111;
        if (model_hazard()) return 4'b0001;
        if (!IMemReady)   return 4'b0110;
        return 4'b1100;
    endfunction

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_fault = 0;
        m_waits = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_edge();
        if (m_boot) begin
            m_boot = 0;
        end else if (!m_halt) begin
            if (PCSrc) begin
                if (m_flushes < 65535) m_flushes++;
                m_waits = 0;
            end else begin
                if (model_hazard() && m_stalls < 65535) m_stalls++;
                if (!IMemReady) begin
                    m_waits++;
                    if (m_waits >= TIMEOUT) begin
                        m_halt = 1;
                        m_fault = 1;
                    end
                end else begin
                    m_waits = 0;
                end
            end
        end
    endtask

    task automatic drive(input bit pcsrc, input bit rdy, input int rs, input int rt,
                         input bit uses_rt, input bit memrd, input int ex_rt);
        PCSrc = pcsrc; IMemReady = rdy;
        ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_UsesRt = uses_rt;
        EX_MemRead = memrd; EX_Rt = 5'(ex_rt);
    endtask

    task automatic clock_edge();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        model_reset();
        #3;
        Reset_n = 1'b1;
        @(posedge Clk); model_edge(); #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        drive(0, 1, 0, 0, 0, 0, 0);
        Reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b0011) begin bad++; $display("FAIL reset_out got=%b exp=0011", got); end
        total++;
        if (Fault !== 1'b0 || StallCount !== 16'd0 || FlushCount !== 16'd0) begin
            bad++; $display("FAIL reset_regs got fault=%b stall=%0d flush=%0d exp 0/0/0",
                            Fault, StallCount, FlushCount);
        end
        Reset_n = 1'b1;
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b0011) begin bad++; $display("FAIL boot_out got=%b exp=0011", got); end
        clock_edge();
        for (int i = 0; i < 5; i++) begin
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
            total++;
            if (got !== 4'b1100) begin bad++; $display("FAIL run_out[%0d] got=%b exp=1100", i, got); end
            clock_edge();
        end
        total++;
        if (StallCount !== 16'd0 || FlushCount !== 16'd0 || Fault !== 1'b0) begin
            bad++; $display("FAIL run_regs got stall=%0d flush=%0d fault=%b exp 0/0/0",
                            StallCount, FlushCount, Fault);
        end
    endtask

    task automatic test_load_use();
        logic [3:0] got;
        do_reset();
        drive(0, 1, 5, 0, 0, 1, 5);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b0001) begin bad++; $display("FAIL stall_out got=%b exp=0001", got); end
        clock_edge();
        total++;
        if (StallCount !== 16'd1) begin bad++; $display("FAIL stall_cnt got=%0d exp=1", StallCount); end
        drive(0, 1, 0, 0, 0, 1, 0);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b1100) begin bad++; $display("FAIL r0_nostall got=%b exp=1100", got); end
        clock_edge();
        drive(0, 1, 1, 9, 1, 1, 9);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b0001) begin bad++; $display("FAIL rt_stall got=%b exp=0001", got); end
        clock_edge();
        drive(0, 1, 1, 9, 0, 1, 9);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b1100) begin bad++; $display("FAIL rt_unused got=%b exp=1100", got); end
        clock_edge();
        total++;
        if (StallCount !== 16'd2) begin bad++; $display("FAIL stall_cnt2 got=%0d exp=2", StallCount); end
    endtask

    task automatic test_redirect_hazard();
        logic [3:0] got;
        do_reset();
        drive(1, 0, 7, 0, 0, 1, 7);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b1111) begin bad++; $display("FAIL redir_out got=%b exp=1111", got); end
        clock_edge();
        total++;
        if (FlushCount !== 16'd1 || StallCount !== 16'd0) begin
            bad++; $display("FAIL redir_cnt got flush=%0d stall=%0d exp 1/0", FlushCount, StallCount);
        end
    endtask

    task automatic test_wait_recovery();
        logic [3:0] got;
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            #1;
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
            total++;
            if (got !== 4'b0110) begin bad++; $display("FAIL wait_out[%0d] got=%b exp=0110", i, got); end
            clock_edge();
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b1100) begin bad++; $display("FAIL wait_recover got=%b exp=1100", got); end
        clock_edge();
        // a fresh run of TIMEOUT-1 misses must still not halt, proving the counter cleared
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (TIMEOUT - 1) clock_edge();
        drive(0, 1, 0, 0, 0, 0, 0);
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (Fault !== 1'b0 || got !== 4'b1100) begin
            bad++; $display("FAIL wait_nofault got fault=%b out=%b exp 0/1100", Fault, got);
        end
        clock_edge();
    endtask

    task automatic test_timeout();
        logic [3:0] got;
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (TIMEOUT) clock_edge();
        total++;
        if (Fault !== 1'b1) begin bad++; $display("FAIL timeout_fault got=%b exp=1", Fault); end
        drive(1, 1, 3, 0, 0, 1, 3);
        for (int i = 0; i < 4; i++) begin
            #1;
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
            total++;
            if (got !== 4'b0110) begin bad++; $display("FAIL halt_out[%0d] got=%b exp=0110", i, got); end
            clock_edge();
        end
        total++;
        if (FlushCount !== 16'd0 || StallCount !== 16'd0) begin
            bad++; $display("FAIL halt_frozen got flush=%0d stall=%0d exp 0/0", FlushCount, StallCount);
        end
        #2;
        Reset_n = 1'b0;
        model_reset();
        #1;
        got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
        total++;
        if (got !== 4'b0011 || Fault !== 1'b0) begin
            bad++; $display("FAIL halt_reset got out=%b fault=%b exp 0011/0", got, Fault);
        end
        Reset_n = 1'b1;
        clock_edge();
    endtask

    task automatic test_random();
        logic [3:0] got;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 65,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3));
            #1;
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
            total++;
            if (got !== exp_out()) begin
                bad++; $display("FAIL rand_out[%0d] got=%b exp=%b", i, got, exp_out());
            end
            if ($urandom_range(0, 99) < 3) begin
                Reset_n = 1'b0;
                model_reset();
                #1;
                got = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble};
                total++;
                if (got !== 4'b0011 || StallCount !== 16'd0 || FlushCount !== 16'd0) begin
                    bad++; $display("FAIL rand_reset[%0d] got out=%b stall=%0d flush=%0d", i, got,
                                    StallCount, FlushCount);
                end
                Reset_n = 1'b1;
            end
            clock_edge();
            total++;
            if (StallCount !== 16'(m_stalls) || FlushCount !== 16'(m_flushes) || Fault !== m_fault) begin
                bad++; $display("FAIL rand_regs[%0d] got stall=%0d flush=%0d fault=%b exp %0d/%0d/%b",
                                i, StallCount, FlushCount, Fault, m_stalls, m_flushes, m_fault);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(0, 1, 6, 0, 0, 1, 6);
        repeat (65534) clock_edge();
        total++;
        if (StallCount !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", StallCount); end
        repeat (6) clock_edge();
        total++;
        if (StallCount !== 16'hFFFF || StallCount !== 16'(m_stalls)) begin
            bad++; $display("FAIL sat_stall got=%h exp=ffff", StallCount);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        clock_edge();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_redirect_hazard();
        test_wait_recovery();
        test_timeout();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_controller.md
# fetch_hazard_controller

Pipeline control block for the fetch stage: decides each cycle whether the PC register advances, whether IF/ID captures, flushes or holds, and whether ID/EX receives a bubble. It handles taken-branch redirects, load-use stalls and slow instruction-memory wait states. A timeout watchdog latches a fault and parks fetch in a halt state. It sits beside the PC mux, PC register and IF/ID register and drives their enables.

## Interface

Parameters:
- TIMEOUT, 15: consecutive not-ready instruction-memory cycles that trigger HALT; must be ≥ 1.
- CW, 4: wait-counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- PCSrc  input  1  branch taken; the PC mux selects BranchPC this cycle.
- IMemReady  input  1  instruction memory output valid this cycle.
- ID_Rs  input  5  rs field of the instruction in ID.
- ID_Rt  input  5  rt field of the instruction in ID.
- ID_UsesRt  input  1  ID instruction reads rt as a source.
- EX_MemRead  input  1  instruction in EX is a load.
- EX_Rt  input  5  destination rt of the load in EX.
- PCWrite  output  1  PC register load enable.
- IFIDWrite  output  1  IF/ID load enable.
- IFIDFlush  output  1  IF/ID loads a NOP (32'h0) instead of the fetched word; only effective with IFIDWrite=1.
- IDEXBubble  output  1  ID/EX control fields zeroed.
- Fault  output  1  sticky fetch-timeout flag.
- StallCount  output  16  saturating count of load-use stall cycles.
- FlushCount  output  16  saturating count of branch redirects.

## Operation

States: BOOT, RUN, WAIT, HALT. Reset forces BOOT.

Hazard term: hz = EX_MemRead & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & (EX_Rt == ID_Rt))).

Outputs are given as {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}.
- BOOT: 0,0,1,1. Next state is RUN unconditionally.
- HALT: 0,1,1,0, so NOPs drain the pipe while the PC holds. HALT persists until reset. Counters are frozen.
- RUN and WAIT use the same fixed-priority evaluation:
  1. PCSrc=1: 1,1,1,1. The redirect wins over every other condition. Wait counter clears, next state is RUN, FlushCount increments.
  2. hz=1: 0,0,0,1. StallCount increments.
  3. IMemReady=0: 0,1,1,0, inserting a NOP and holding the PC.
  4. Otherwise: 1,1,0,0.
- The wait counter (CW bits) tracks consecutive cycles with PCSrc=0 and IMemReady=0 in RUN or WAIT. Such a cycle increments it even if hz=1.
  - If the counter equals TIMEOUT-1 on such a cycle, the next state is HALT and Fault is set.
  - Otherwise the next state is WAIT.
- Any cycle with IMemReady=1 or PCSrc=1 clears the wait counter and returns to RUN.
- StallCount and FlushCount saturate at 16'hFFFF and never wrap.
- Fault clears only on reset.

## Timing

- All four enables are combinational from the current state and current inputs, with zero latency. They are intended to be sampled by the PC and IF/ID registers on the same rising edge.
- State, wait counter, Fault and both performance counters update on the rising Clk edge.
- A counter increments on the edge that ends the qualifying cycle.
- Reset_n low asynchronously forces:
  - State BOOT, so outputs are 0,0,1,1.
  - Fault=0, StallCount=0, FlushCount=0, wait counter=0.
- Reset takes effect mid-stall, mid-wait or in HALT alike.
- First release: the first rising edge after Reset_n rises moves BOOT to RUN. The first PC advance occurs on the following edge, provided IMemReady=1.
- A load-use stall lasts exactly one cycle per hazard occurrence, because the load leaves EX on the next edge.
- PCSrc together with hz or IMemReady=0 in the same cycle: only the redirect is acted on, and StallCount does not increment.
- TIMEOUT=1: the first not-ready cycle enters HALT.

## Test plan

- Reset then release with IMemReady=1, no hazards: outputs are 0,0,1,1 during reset and for one cycle after release, then 1,1,0,0 every cycle. All counters read 0.
- Load-use stall: EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle gives 0,0,0,1 and StallCount=1. Repeating with EX_Rt=0 gives no stall.
- Redirect with simultaneous hazard: PCSrc=1 with hz=1 gives 1,1,1,1, FlushCount=1, StallCount unchanged.
- Memory wait recovery: TIMEOUT=4, IMemReady low for 3 cycles then high. Outputs are 0,1,1,0 for 3 cycles, then 1,1,0,0. Fault stays 0 and the state returns to RUN.
- Timeout: TIMEOUT=4, IMemReady low for 4 cycles. After the 4th edge, Fault=1 and outputs are 0,1,1,0 permanently, even with IMemReady=1 and PCSrc=1. Asserting Reset_n low clears Fault and the outputs return to 0,0,1,1.
- Saturation: hold hz=1 for 65 540 cycles. StallCount stops at 16'hFFFF.
